// File: rtl/cache_mem_ctrl_pkg.sv
// Shared cache/memory type package: request/response buses and memory controller states.
package cache_def;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  localparam int MEM_LAT_DEF = 8;
  localparam int LINE_WORDS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } memctrl_state_type;

  // Latency counter preload: WAIT runs LAT cycles, counting LAT-1 down to 0.
  function automatic logic [7:0] lat_load(input int lat);
    return 8'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// 32-bit word RAM behind the memory controller: synchronous write, asynchronous read, no reset.
module mem_word_ram #(
  parameter  int DEPTH_WORDS = 16384,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/cache_mem_ctrl.sv
// Fixed-latency main-memory controller moving 128-bit lines as 4-beat bursts over a word RAM.
// Optional MEMCTRL_STATS_EN adds rd_count/wr_count completion counters.
module cache_mem_ctrl
  import cache_def::*;
#(
  parameter int LAT         = MEM_LAT_DEF,
  parameter int DEPTH_WORDS = 16384
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data
`ifdef MEMCTRL_STATS_EN
  ,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
`endif
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [7:0] LAT_LOAD = lat_load(LAT);
  localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);

  memctrl_state_type r_state, w_state_nxt;
  logic [7:0]        r_lat_cnt;
  logic [1:0]        r_beat;
  logic [AW-3:0]     r_cap_line;
  logic [127:0]      r_cap_data;
  logic              r_cap_rw;
  logic [127:0]      r_line_q;

  logic              w_accept;
  logic              w_xfer;
  logic              w_last_beat;
  logic              w_we;
  logic [AW-1:0]     w_word_addr;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic              w_unused_addr;

  // Line offset and bits above the RAM depth play no part in addressing.
  assign w_unused_addr = ^{mem_req.addr[31:AW+2], mem_req.addr[3:0]};

  assign w_accept    = mem_req.valid && (r_state == IDLE || r_state == RESP);
  assign w_xfer      = (r_state == XFER);
  assign w_last_beat = w_xfer && (r_beat == LAST_BEAT);
  assign w_word_addr = {r_cap_line, r_beat};
  assign w_we        = w_xfer && r_cap_rw;
  assign w_wdata     = r_cap_data[{r_beat, 5'd0} +: 32];

  mem_word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (w_we),
    .waddr(w_word_addr),
    .wdata(w_wdata),
    .raddr(w_word_addr),
    .rdata(w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (mem_req.valid) w_state_nxt = WAIT;
      WAIT:    if (r_lat_cnt == 8'd0) w_state_nxt = XFER;
      XFER:    if (r_beat == LAST_BEAT) w_state_nxt = RESP;
      RESP:    w_state_nxt = mem_req.valid ? WAIT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_lat_cnt  <= 8'd0;
      r_beat     <= 2'd0;
      r_cap_line <= '0;
      r_cap_data <= '0;
      r_cap_rw   <= 1'b0;
      r_line_q   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cap_line <= mem_req.addr[AW+1:4];
        r_cap_data <= mem_req.data;
        r_cap_rw   <= mem_req.rw;
        r_lat_cnt  <= LAT_LOAD;
      end else if (r_state == WAIT && r_lat_cnt != 8'd0) begin
        r_lat_cnt <= r_lat_cnt - 8'd1;
      end
      if (r_state == WAIT) r_beat <= 2'd0;
      else if (w_xfer)     r_beat <= r_beat + 2'd1;
      // Read beats land in line_q; writes and idle leave it untouched.
      if (w_xfer && !r_cap_rw) r_line_q[{r_beat, 5'd0} +: 32] <= w_rdata;
    end
  end

`ifdef MEMCTRL_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_count <= 32'd0;
      r_wr_count <= 32'd0;
    end else if (w_last_beat) begin
      if (r_cap_rw) r_wr_count <= r_wr_count + 32'd1;
      else          r_rd_count <= r_rd_count + 32'd1;
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`else
  logic w_unused_last;
  assign w_unused_last = w_last_beat;
`endif

  assign mem_data.data  = r_line_q;
  assign mem_data.ready = (r_state == RESP);

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: latency, burst data, back-to-back, busy-ignore, wrap, reset abort.
module tb_cache_mem_ctrl;
  import cache_def::*;

  localparam int LAT = 8;
  localparam int EXP = LAT + 4;

  logic         clk = 1'b0;
  logic         rst;
  mem_req_type  mem_req;
  mem_data_type mem_data;
`ifdef MEMCTRL_STATS_EN
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [127:0] L_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] L_B = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L_C = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
  localparam logic [127:0] L_D = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
  localparam logic [127:0] L_E = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] L_F = 128'hFFFFFFFF_EEEEEEEE_99999999_A5A5A5A5;

  always #5 clk = ~clk;

  cache_mem_ctrl #(
    .LAT(LAT),
    .DEPTH_WORDS(16384)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_req (mem_req),
    .mem_data(mem_data)
`ifdef MEMCTRL_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [127:0] d, input logic rw, input logic v);
    mem_req.addr  = a;
    mem_req.data  = d;
    mem_req.rw    = rw;
    mem_req.valid = v;
  endtask

  // Counts edges from the accept edge until ready is seen (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!mem_data.ready && n < 200);
  endtask

  // One full transaction ending back in IDLE; n = edges from accept to ready.
  task automatic txn(input logic [31:0] a, input logic [127:0] d, input logic rw, output int n);
    drive(a, d, rw, 1'b1);
    tick();
    mem_req.valid = 1'b0;
    wait_ready(n);
    tick();
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b0;
    drive(32'h0000_1230, L_A, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (mem_data.ready !== 1'b0) $display("FAIL reset_ready[%0d]: got %b expected 0", i, mem_data.ready);
      else n_pass++;
      n_total++;
      if (mem_data.data !== 128'd0) $display("FAIL reset_data[%0d]: got %h expected 0", i, mem_data.data);
      else n_pass++;
    end
    mem_req.valid = 1'b0;
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < EXP + 4; i++) begin
      tick();
      if (mem_data.ready) pulses++;
    end
    n_total++;
    if (pulses !== 0) $display("FAIL reset_no_txn: got %0d ready pulses expected 0", pulses);
    else n_pass++;
  endtask

  task automatic test_write_read();
    int n;
    txn(32'h0000_1230, L_A, 1'b1, n);
    n_total++;
    if (n !== EXP) $display("FAIL wr_latency: got %0d edges expected %0d", n, EXP);
    else n_pass++;
    n_total++;
    if (mem_data.data !== 128'd0) $display("FAIL wr_no_data_update: got %h expected 0", mem_data.data);
    else n_pass++;
    txn(32'h0000_1234, 128'd0, 1'b0, n);
    n_total++;
    if (n !== EXP) $display("FAIL rd_latency: got %0d edges expected %0d", n, EXP);
    else n_pass++;
    n_total++;
    if (mem_data.data !== L_A) $display("FAIL rd_data: got %h expected %h", mem_data.data, L_A);
    else n_pass++;
    n_total++;
    if (mem_data.data[31:0] !== 32'hAAAA_AAAA) $display("FAIL rd_word0: got %h expected aaaaaaaa", mem_data.data[31:0]);
    else n_pass++;
    for (int i = 0; i < 5; i++) tick();
    n_total++;
    if (mem_data.data !== L_A) $display("FAIL rd_data_hold: got %h expected %h", mem_data.data, L_A);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    txn(32'h0000_0080, L_B, 1'b1, n);
    drive(32'h0000_0040, L_C, 1'b1, 1'b1);
    tick();
    mem_req.valid = 1'b0;
    wait_ready(n);
    n_total++;
    if (n !== EXP) $display("FAIL b2b_wr_latency: got %0d expected %0d", n, EXP);
    else n_pass++;
    // Raised during the ready cycle, as the cache's write-back -> allocate handoff does.
    drive(32'h0000_0080, 128'd0, 1'b0, 1'b1);
    tick();
    mem_req.valid = 1'b0;
    n_total++;
    if (mem_data.ready !== 1'b0) $display("FAIL b2b_ready_drop: got %b expected 0", mem_data.ready);
    else n_pass++;
    wait_ready(n);
    n_total++;
    if (n !== EXP) $display("FAIL b2b_rd_latency: got %0d expected %0d", n, EXP);
    else n_pass++;
    n_total++;
    if (mem_data.data !== L_B) $display("FAIL b2b_rd_data: got %h expected %h", mem_data.data, L_B);
    else n_pass++;
    tick();
  endtask

  task automatic test_valid_held();
    int pulses, k1, k2;
    drive(32'h0000_0100, L_D, 1'b1, 1'b1);
    tick();
    pulses = 0; k1 = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (mem_data.ready) begin
        pulses++;
        if (pulses == 1) k1 = k;
        mem_req.valid = 1'b0;
      end
    end
    n_total++;
    if (pulses !== 1) $display("FAIL held_one_pulse: got %0d pulses expected 1", pulses);
    else n_pass++;
    n_total++;
    if (k1 !== EXP) $display("FAIL held_first_ready: got edge %0d expected %0d", k1, EXP);
    else n_pass++;
    drive(32'h0000_0100, 128'd0, 1'b0, 1'b1);
    tick();
    pulses = 0; k1 = 0; k2 = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (mem_data.ready) begin
        pulses++;
        if (pulses == 1) k1 = k;
        if (pulses == 2) begin
          k2 = k;
          mem_req.valid = 1'b0;
        end
      end
    end
    n_total++;
    if (pulses !== 2) $display("FAIL held_resp_pulses: got %0d pulses expected 2", pulses);
    else n_pass++;
    n_total++;
    if (k2 !== 2 * EXP + 1) $display("FAIL held_second_ready: got edge %0d expected %0d (first at %0d)", k2, 2 * EXP + 1, k1);
    else n_pass++;
    n_total++;
    if (mem_data.data !== L_D) $display("FAIL held_rd_data: got %h expected %h", mem_data.data, L_D);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int n;
    txn(32'h0001_0000, L_E, 1'b1, n);
    txn(32'h0000_0000, 128'd0, 1'b0, n);
    n_total++;
    if (mem_data.data !== L_E) $display("FAIL wrap_data: got %h expected %h", mem_data.data, L_E);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n, pulses;
    txn(32'h0000_0200, L_C, 1'b1, n);
    txn(32'h0000_0200, 128'd0, 1'b0, n);
    drive(32'h0000_0200, L_F, 1'b1, 1'b1);
    tick();
    mem_req.valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    tick();
    n_total++;
    if (mem_data.ready !== 1'b0) $display("FAIL mid_rst_ready: got %b expected 0", mem_data.ready);
    else n_pass++;
    n_total++;
    if (mem_data.data !== 128'd0) $display("FAIL mid_rst_data: got %h expected 0", mem_data.data);
    else n_pass++;
    tick();
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_data.ready) pulses++;
    end
    n_total++;
    if (pulses !== 0) $display("FAIL mid_rst_no_ready: got %0d pulses expected 0", pulses);
    else n_pass++;
    txn(32'h0000_0200, 128'd0, 1'b0, n);
    n_total++;
    if (mem_data.data !== L_C) $display("FAIL mid_rst_old_line: got %h expected %h", mem_data.data, L_C);
    else n_pass++;
`ifdef MEMCTRL_STATS_EN
    txn(32'h0000_0300, L_A, 1'b1, n);
    txn(32'h0000_0340, L_B, 1'b1, n);
    n_total++;
    if (wr_count !== 32'd2) $display("FAIL stats_wr: got %0d expected 2", wr_count);
    else n_pass++;
    n_total++;
    if (rd_count !== 32'd1) $display("FAIL stats_rd: got %0d expected 1", rd_count);
    else n_pass++;
`endif
  endtask

  initial begin
    drive(32'd0, 128'd0, 1'b0, 1'b0);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_valid_held();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
